xadc_sample_avg: RTL and testbench
==================================

XADC_SAMPLE_AVG -- requirements
Module: xadc_sample_avg

Interface
REQ-001 Parameter CHAN_ADDR, default 7'h16, SHALL be the DRP status register address read (VAUXP6/VAUXN6 result).
REQ-002 Parameter LOG2_N, default 4, range 1..6, SHALL set the samples per average, N = 2^LOG2_N.
REQ-003 Parameter DRDY_TIMEOUT, default 64, SHALL set the maximum cycles from DRP strobe to drdy_in.
REQ-004 CLK100MHZ  in  1  sole clock; all logic SHALL be on its rising edge.
REQ-005 reset_n  in  1  reset, synchronous, active-low.
REQ-006 eoc_in  in  1  end-of-conversion pulse from the XADC wizard.
REQ-007 drdy_in  in  1  DRP data-ready from the XADC wizard.
REQ-008 do_in  in  16  DRP read data; the result is in bits [15:4].
REQ-009 den_out  out  1  DRP enable strobe to the XADC wizard.
REQ-010 daddr_out  out  7  DRP address; SHALL equal CHAN_ADDR at all times.
REQ-011 sample_out  out  12  averaged sample.
REQ-012 sample_valid  out  1  sample_out holds an unconsumed average.
REQ-013 sample_ready  in  1  the consumer accepts sample_out this cycle.
REQ-014 overrun  out  1  sticky flag: an unconsumed average was overwritten.
REQ-015 timeout_err  out  1  sticky flag: drdy_in did not arrive within DRDY_TIMEOUT cycles.

Function
REQ-016 The FSM SHALL have three states: IDLE, READ and DONE.
REQ-017 In IDLE, eoc_in=1 SHALL drive den_out=1 for exactly the next cycle and move the FSM to READ.
REQ-018 In READ, eoc_in SHALL be ignored and SHALL NOT generate a second strobe.
REQ-019 In READ, drdy_in=1 SHALL capture do_in[15:4], add it to the accumulator (width 12+LOG2_N, no overflow possible) and increment the sample count.
REQ-020 In READ, the FSM SHALL go to DONE if the count reaches N on that capture, and otherwise return to IDLE.
REQ-021 In READ, if drdy_in has not arrived DRDY_TIMEOUT cycles after den_out, the read SHALL be discarded: accumulator and count unchanged, timeout_err set to 1, FSM returns to IDLE.
REQ-022 In DONE, the block SHALL load sample_out with accumulator >> LOG2_N (truncation, no rounding).
REQ-023 In DONE, the block SHALL set sample_valid=1, clear the accumulator and count, and return to IDLE; DONE lasts exactly one cycle.
REQ-024 Latency SHALL be 2 cycles from the drdy_in of the Nth sample to sample_valid=1.
REQ-025 A handshake SHALL occur when sample_valid=1 and sample_ready=1; sample_valid SHALL clear on the next cycle unless a new average loads in the same cycle.
REQ-026 A DONE load while sample_valid=1 and sample_ready=0 SHALL overwrite sample_out and set overrun to 1; sample_valid stays 1.
REQ-027 A DONE load in the same cycle as a handshake SHALL NOT set overrun; sample_valid stays 1 with the new value.
REQ-028 sample_out SHALL be stable while sample_valid=1, except on a DONE load.
REQ-029 overrun and timeout_err SHALL clear only on reset.

Reset
REQ-030 While reset_n=0 at a clock edge: FSM to IDLE; accumulator, count and timeout counter to 0; den_out, sample_valid, overrun and timeout_err to 0; sample_out to 12'h000.
REQ-031 Reset during READ or mid-average SHALL discard the partial accumulation.
REQ-032 A drdy_in arriving after reset releases SHALL be ignored unless the FSM is in READ.

Structure
REQ-033 Package xadc_pkg SHALL hold the FSM state enum, CHAN_ADDR_VAUX6 = 7'h16 and the DRP result slice constants (MSB 15, LSB 4).
REQ-034 The block SHALL contain no sub-module; the DRP read FSM and the accumulator SHALL share one always block per register group.

Verification
REQ-035 16 eoc/drdy reads with do_in=16'h8000 and sample_ready=1 -> exactly one sample_valid pulse with sample_out=12'h800; overrun=0.
REQ-036 16 reads with do_in = k<<4 for k=0..15 -> sample_out=12'h007 (sum 120 >> 4).
REQ-037 sample_ready=0 across two full averages (16×12'hFFF, then 16×12'h000) -> sample_out=12'h000, sample_valid=1, overrun=1.
REQ-038 eoc_in with drdy_in held low for 70 cycles -> timeout_err=1; the next 16 good reads of 12'h100 -> sample_out=12'h100.
REQ-039 reset_n=0 for one cycle after 8 reads of 12'hFFF, then 16 reads of 12'h010 -> sample_out=12'h010.
REQ-040 Second eoc_in during READ -> den_out pulses exactly once per read (checked by assertion).

Source files
------------

// File: rtl/xadc_pkg.sv
// ============================================================================
// xadc_pkg : shared types and DRP constants for the XADC sample averager
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package xadc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [6:0] CHAN_ADDR_VAUX6 = 7'h16;

   // The XADC places its 12-bit conversion result in the upper bits of DO.
   localparam int DRP_RES_MSB = 15;
   localparam int DRP_RES_LSB = 4;
   localparam int RES_W       = DRP_RES_MSB - DRP_RES_LSB + 1;

endpackage

`default_nettype wire

// File: rtl/xadc_sample_avg.sv
// ============================================================================
// xadc_sample_avg : DRP reader that averages 2^LOG2_N XADC conversions
// Rev 1.0         : initial release
// ============================================================================
`default_nettype none

module xadc_sample_avg
   import xadc_pkg::*;
#(
   parameter logic [6:0] CHAN_ADDR    = CHAN_ADDR_VAUX6,
   parameter int         LOG2_N       = 4,
   parameter int         DRDY_TIMEOUT = 64
) (
   input  logic              CLK100MHZ,
   input  logic              reset_n,
   input  logic              eoc_in,
   input  logic              drdy_in,
   input  logic [15:0]       do_in,
   output logic              den_out,
   output logic [6:0]        daddr_out,
   output logic [RES_W-1:0]  sample_out,
   output logic              sample_valid,
   input  logic              sample_ready,
   output logic              overrun,
   output logic              timeout_err
);

   localparam int ACC_W = RES_W + LOG2_N;
   localparam int CNT_W = LOG2_N + 1;
   localparam int TMO_W = $clog2(DRDY_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] N_SAMPLES = CNT_W'(1 << LOG2_N);
   localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(DRDY_TIMEOUT - 1);

   state_t              state_q,   state_d;
   logic                den_q,     den_d;
   logic [ACC_W-1:0]    acc_q,     acc_d;
   logic [CNT_W-1:0]    cnt_q,     cnt_d;
   logic [TMO_W-1:0]    tmo_q,     tmo_d;
   logic [RES_W-1:0]    sample_q,  sample_d;
   logic                valid_q,   valid_d;
   logic                overrun_q, overrun_d;
   logic                timeout_q, timeout_d;

   logic [RES_W-1:0]    result;
   logic [CNT_W-1:0]    cnt_inc;
   logic                unused_do_lsbs;

   assign result         = do_in[DRP_RES_MSB:DRP_RES_LSB];
   assign unused_do_lsbs = ^do_in[DRP_RES_LSB-1:0];
   assign cnt_inc        = cnt_q + CNT_W'(1);

   always_comb begin
      state_d   = state_q;
      den_d     = 1'b0;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      tmo_d     = tmo_q;
      sample_d  = sample_q;
      valid_d   = valid_q;
      overrun_d = overrun_q;
      timeout_d = timeout_q;

      // A DONE load below overrides this clear when both happen together.
      if (valid_q && sample_ready) begin
         valid_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (eoc_in) begin
               den_d   = 1'b1;
               tmo_d   = '0;
               state_d = ST_READ;
            end
         end
         ST_READ: begin
            if (drdy_in) begin
               acc_d   = acc_q + ACC_W'(result);
               cnt_d   = cnt_inc;
               state_d = (cnt_inc == N_SAMPLES) ? ST_DONE : ST_IDLE;
            end else if (tmo_q == TMO_LAST) begin
               timeout_d = 1'b1;
               state_d   = ST_IDLE;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         ST_DONE: begin
            sample_d = acc_q[ACC_W-1:LOG2_N];
            valid_d  = 1'b1;
            if (valid_q && !sample_ready) begin
               overrun_d = 1'b1;
            end
            acc_d   = '0;
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK100MHZ) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         den_q     <= 1'b0;
         acc_q     <= '0;
         cnt_q     <= '0;
         tmo_q     <= '0;
         sample_q  <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         den_q     <= den_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         tmo_q     <= tmo_d;
         sample_q  <= sample_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
         timeout_q <= timeout_d;
      end
   end

   assign den_out      = den_q;
   assign daddr_out    = CHAN_ADDR;
   assign sample_out   = sample_q;
   assign sample_valid = valid_q;
   assign overrun      = overrun_q;
   assign timeout_err  = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_xadc_sample_avg.sv
// ============================================================================
// tb_xadc_sample_avg : directed self-checking bench for xadc_sample_avg
// Rev 1.0            : initial release
// ============================================================================
`default_nettype none

module tb_xadc_sample_avg;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        eoc_in = 1'b0;
   logic        drdy_in = 1'b0;
   logic [15:0] do_in = 16'h0;
   logic        sample_ready = 1'b0;
   logic        den_out;
   logic [6:0]  daddr_out;
   logic [11:0] sample_out;
   logic        sample_valid;
   logic        overrun;
   logic        timeout_err;

   int n_checks = 0;
   int n_pass = 0;
   int den_cnt = 0;
   int den_double = 0;
   int valid_pulses = 0;
   logic den_prev = 1'b0;
   logic valid_prev = 1'b0;

   always #5 clk = ~clk;

   xadc_sample_avg dut (
      .CLK100MHZ    (clk),
      .reset_n      (reset_n),
      .eoc_in       (eoc_in),
      .drdy_in      (drdy_in),
      .do_in        (do_in),
      .den_out      (den_out),
      .daddr_out    (daddr_out),
      .sample_out   (sample_out),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .overrun      (overrun),
      .timeout_err  (timeout_err)
   );

   // Strobe and valid-pulse monitor, sampled away from the active edge.
   always @(negedge clk) begin
      if (den_out === 1'b1) den_cnt <= den_cnt + 1;
      if (den_out === 1'b1 && den_prev === 1'b1) den_double <= den_double + 1;
      assert (!(den_out === 1'b1 && den_prev === 1'b1))
         else $error("FAIL den_double: den_out high on two consecutive cycles");
      if (sample_valid === 1'b1 && valid_prev !== 1'b1) valid_pulses <= valid_pulses + 1;
      den_prev   <= den_out;
      valid_prev <= sample_valid;
   end

   // Starts and ends on a falling edge; the capture edge lies inside.
   task automatic do_read(input logic [11:0] v, input logic [3:0] nib);
      eoc_in = 1'b1;
      @(negedge clk);
      eoc_in  = 1'b0;
      drdy_in = 1'b1;
      do_in   = {v, nib};
      @(negedge clk);
      drdy_in = 1'b0;
      do_in   = 16'h0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++; if (den_out !== 1'b0) $display("FAIL rst_den: got %b want 0", den_out); else n_pass++;
      n_checks++; if (sample_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", sample_valid); else n_pass++;
      n_checks++; if (sample_out !== 12'h000) $display("FAIL rst_sample: got %h want 000", sample_out); else n_pass++;
      n_checks++; if (overrun !== 1'b0 || timeout_err !== 1'b0)
         $display("FAIL rst_flags: got ovr=%b tmo=%b want 0/0", overrun, timeout_err); else n_pass++;
      n_checks++; if (daddr_out !== 7'h16) $display("FAIL daddr: got %h want 16", daddr_out); else n_pass++;
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++; if (den_out !== 1'b0) $display("FAIL idle_den: got %b want 0", den_out); else n_pass++;
   endtask

   task automatic test_full_scale();
      int v0;
      v0 = valid_pulses;
      sample_ready = 1'b1;
      for (int i = 0; i < 16; i++) do_read(12'h800, 4'h0);
      n_checks++; if (sample_valid !== 1'b0) $display("FAIL latency_early: got valid=%b want 0", sample_valid); else n_pass++;
      @(negedge clk);
      n_checks++; if (sample_valid !== 1'b1) $display("FAIL latency: got valid=%b want 1", sample_valid); else n_pass++;
      n_checks++; if (sample_out !== 12'h800) $display("FAIL avg_800: got %h want 800", sample_out); else n_pass++;
      n_checks++; if (overrun !== 1'b0) $display("FAIL ovr_800: got %b want 0", overrun); else n_pass++;
      repeat (3) @(negedge clk);
      n_checks++; if (sample_valid !== 1'b0) $display("FAIL consume_800: got valid=%b want 0", sample_valid); else n_pass++;
      n_checks++; if (valid_pulses - v0 != 1) $display("FAIL pulses_800: got %0d want 1", valid_pulses - v0); else n_pass++;
   endtask

   task automatic test_ramp();
      sample_ready = 1'b1;
      for (int k = 0; k < 16; k++) do_read(12'(k), 4'h0);
      @(negedge clk);
      n_checks++; if (sample_out !== 12'h007 || sample_valid !== 1'b1)
         $display("FAIL ramp: got %h valid=%b want 007 valid=1", sample_out, sample_valid); else n_pass++;
      @(negedge clk);
      n_checks++; if (sample_valid !== 1'b0) $display("FAIL ramp_consume: got valid=%b want 0", sample_valid); else n_pass++;
   endtask

   task automatic test_load_with_handshake();
      sample_ready = 1'b0;
      for (int i = 0; i < 16; i++) do_read(12'h123, 4'h0);
      @(negedge clk);
      n_checks++; if (sample_out !== 12'h123 || sample_valid !== 1'b1)
         $display("FAIL hs_first: got %h valid=%b want 123 valid=1", sample_out, sample_valid); else n_pass++;
      for (int i = 0; i < 16; i++) do_read(12'h456, 4'h0);
      n_checks++; if (sample_out !== 12'h123) $display("FAIL hs_stable: got %h want 123", sample_out); else n_pass++;
      sample_ready = 1'b1;
      @(negedge clk);
      n_checks++; if (sample_out !== 12'h456 || sample_valid !== 1'b1 || overrun !== 1'b0)
         $display("FAIL hs_load: got %h valid=%b ovr=%b want 456 1 0", sample_out, sample_valid, overrun); else n_pass++;
      @(negedge clk);
      n_checks++; if (sample_valid !== 1'b0) $display("FAIL hs_consume: got valid=%b want 0", sample_valid); else n_pass++;
   endtask

   task automatic test_overrun();
      sample_ready = 1'b0;
      for (int i = 0; i < 16; i++) do_read(12'hFFF, 4'h0);
      @(negedge clk);
      n_checks++; if (sample_out !== 12'hFFF || overrun !== 1'b0)
         $display("FAIL ovr_first: got %h ovr=%b want FFF 0", sample_out, overrun); else n_pass++;
      for (int i = 0; i < 16; i++) do_read(12'h000, 4'h0);
      n_checks++; if (overrun !== 1'b0 || sample_out !== 12'hFFF)
         $display("FAIL ovr_early: got %h ovr=%b want FFF 0", sample_out, overrun); else n_pass++;
      @(negedge clk);
      n_checks++; if (sample_out !== 12'h000 || sample_valid !== 1'b1 || overrun !== 1'b1)
         $display("FAIL ovr_set: got %h valid=%b ovr=%b want 000 1 1", sample_out, sample_valid, overrun); else n_pass++;
      sample_ready = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++; if (sample_valid !== 1'b0 || overrun !== 1'b1)
         $display("FAIL ovr_sticky: got valid=%b ovr=%b want 0 1", sample_valid, overrun); else n_pass++;
      do_reset();
      n_checks++; if (overrun !== 1'b0) $display("FAIL ovr_clear: got %b want 0", overrun); else n_pass++;
   endtask

   task automatic test_timeout();
      sample_ready = 1'b1;
      eoc_in = 1'b1;
      @(negedge clk);
      eoc_in = 1'b0;
      repeat (63) @(negedge clk);
      n_checks++; if (timeout_err !== 1'b0) $display("FAIL tmo_early: got %b want 0", timeout_err); else n_pass++;
      @(negedge clk);
      n_checks++; if (timeout_err !== 1'b1) $display("FAIL tmo_set: got %b want 1", timeout_err); else n_pass++;
      repeat (5) @(negedge clk);
      drdy_in = 1'b1;
      do_in   = 16'hFFFF;
      @(negedge clk);
      drdy_in = 1'b0;
      do_in   = 16'h0;
      for (int i = 0; i < 16; i++) do_read(12'h100, 4'h5);
      @(negedge clk);
      n_checks++; if (sample_out !== 12'h100 || sample_valid !== 1'b1)
         $display("FAIL tmo_avg: got %h valid=%b want 100 1", sample_out, sample_valid); else n_pass++;
      n_checks++; if (timeout_err !== 1'b1) $display("FAIL tmo_sticky: got %b want 1", timeout_err); else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      sample_ready = 1'b1;
      for (int i = 0; i < 8; i++) do_read(12'hFFF, 4'h0);
      eoc_in = 1'b1;
      @(negedge clk);
      eoc_in  = 1'b0;
      reset_n = 1'b0;
      @(negedge clk);
      n_checks++; if (den_out !== 1'b0 || timeout_err !== 1'b0)
         $display("FAIL mid_rst: got den=%b tmo=%b want 0 0", den_out, timeout_err); else n_pass++;
      reset_n = 1'b1;
      drdy_in = 1'b1;
      do_in   = 16'hFFF0;
      @(negedge clk);
      drdy_in = 1'b0;
      do_in   = 16'h0;
      for (int i = 0; i < 16; i++) do_read(12'h010, 4'h0);
      @(negedge clk);
      n_checks++; if (sample_out !== 12'h010 || sample_valid !== 1'b1)
         $display("FAIL mid_avg: got %h valid=%b want 010 1", sample_out, sample_valid); else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_double_eoc();
      int d0;
      d0 = den_cnt;
      eoc_in = 1'b1;
      @(negedge clk);
      @(negedge clk);
      n_checks++; if (den_out !== 1'b0) $display("FAIL dbl_den: got %b want 0", den_out); else n_pass++;
      eoc_in  = 1'b0;
      drdy_in = 1'b1;
      do_in   = 16'h2340;
      @(negedge clk);
      drdy_in = 1'b0;
      do_in   = 16'h0;
      repeat (2) @(negedge clk);
      n_checks++; if (den_cnt - d0 != 1) $display("FAIL dbl_count: got %0d want 1", den_cnt - d0); else n_pass++;
      n_checks++; if (den_double != 0) $display("FAIL dbl_consec: got %0d want 0", den_double); else n_pass++;
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_full_scale();
      test_ramp();
      test_load_with_handshake();
      test_overrun();
      test_timeout();
      test_reset_mid();
      test_double_eoc();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
